// File: rtl/turn_around_fifo_pkg.sv
// Shared encodings and beat-width helpers for the turn-around FIFO stage.
package turn_around_fifo_pkg;

    localparam int unsigned TYPE_WIDTH = 2;
    localparam logic [TYPE_WIDTH-1:0] TYPE_IDLE = '0;

    localparam int unsigned CMD_IDLE   = 0;
    localparam int unsigned CMD_PAUSE  = 1;
    localparam int unsigned CMD_RESUME = 2;

    typedef enum logic {StRun, StHeld} flow_state_e;

    // Width of one packed FIFO word {Last, StreamID, ChunkID, ChannelID, State, Type, Data}.
    function automatic int unsigned beat_width(input int unsigned data_w,
                                               input int unsigned stream_w,
                                               input int unsigned chunk_w,
                                               input int unsigned channel_w,
                                               input int unsigned state_w);
        return 1 + stream_w + chunk_w + channel_w + state_w + TYPE_WIDTH + data_w;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; the head is visible on rd_data whenever non-empty.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    // A write into a full FIFO is accepted only when the head leaves on the same edge.
    assign wr_ok = wr_en && (!full || rd_en);
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && wr_ok) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/turn_around_fifo.sv
// Far-end stream stage: turns forward beats around through a FIFO and manages pause/resume
// in both directions, generating its own upstream requests from fill watermarks.
module turn_around_fifo
    import turn_around_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH                  = 512,
    parameter int unsigned STREAM_ID_NUM               = 16,
    parameter int unsigned CHUNK_ID_NUM                = 32,
    parameter int unsigned CHANNEL_ID_NUM              = 1024,
    parameter int unsigned STREAM_ID_WIDTH             = $clog2(STREAM_ID_NUM),
    parameter int unsigned CHUNK_ID_WIDTH              = $clog2(CHUNK_ID_NUM),
    parameter int unsigned CHANNEL_ID_WIDTH            = $clog2(CHANNEL_ID_NUM),
    parameter int unsigned STATE_WIDTH                 = 32,
    parameter int unsigned INSTRUCTION_WIDTH           = 2,
    parameter int unsigned INSTRUCTION_PARAMETER_WIDTH = 16,
    parameter int unsigned INSTRUCTION_CMD_IDLE        = CMD_IDLE,
    parameter int unsigned INSTRUCTION_CMD_PAUSE       = CMD_PAUSE,
    parameter int unsigned INSTRUCTION_CMD_RESUME      = CMD_RESUME,
    parameter int unsigned DEPTH                       = 16,
    parameter int unsigned HIGH_WATER                  = 12,
    parameter int unsigned LOW_WATER                   = 4,
    parameter int unsigned DROP_CNT_WIDTH              = 16
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [DATA_WIDTH-1:0]                  dirOneFront_Data,
    input  logic [TYPE_WIDTH-1:0]                  dirOneFront_Type,
    input  logic                                   dirOneFront_Last,
    input  logic [STREAM_ID_WIDTH-1:0]             dirOneFront_StreamID,
    input  logic [CHUNK_ID_WIDTH-1:0]              dirOneFront_ChunkID,
    input  logic [CHANNEL_ID_WIDTH-1:0]            dirOneFront_ChannelID,
    input  logic [STATE_WIDTH-1:0]                 dirOneFront_State,
    output logic [INSTRUCTION_WIDTH-1:0]           dirOneFront_InstructionType,
    output logic [STREAM_ID_WIDTH-1:0]             dirOneFront_InstructionStreamID,
    output logic [CHANNEL_ID_WIDTH-1:0]            dirOneFront_InstructionChannelID,
    output logic [INSTRUCTION_PARAMETER_WIDTH-1:0] dirOneFront_InstructionParameter,
    output logic [DATA_WIDTH-1:0]                  dirTwoBack_Data,
    output logic [TYPE_WIDTH-1:0]                  dirTwoBack_Type,
    output logic                                   dirTwoBack_Last,
    output logic [STREAM_ID_WIDTH-1:0]             dirTwoBack_StreamID,
    output logic [CHUNK_ID_WIDTH-1:0]              dirTwoBack_ChunkID,
    output logic [CHANNEL_ID_WIDTH-1:0]            dirTwoBack_ChannelID,
    output logic [STATE_WIDTH-1:0]                 dirTwoBack_State,
    input  logic [INSTRUCTION_WIDTH-1:0]           dirTwoBack_InstructionType,
    input  logic [STREAM_ID_WIDTH-1:0]             dirTwoBack_InstructionStreamID,
    input  logic [CHANNEL_ID_WIDTH-1:0]            dirTwoBack_InstructionChannelID,
    input  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] dirTwoBack_InstructionParameter,
    output logic [$clog2(DEPTH):0]                 fill_level,
    output logic [DROP_CNT_WIDTH-1:0]              drop_count
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned BEAT_W = beat_width(DATA_WIDTH, STREAM_ID_WIDTH, CHUNK_ID_WIDTH,
                                                CHANNEL_ID_WIDTH, STATE_WIDTH);

    localparam logic [INSTRUCTION_WIDTH-1:0] CMD_I = INSTRUCTION_WIDTH'(INSTRUCTION_CMD_IDLE);
    localparam logic [INSTRUCTION_WIDTH-1:0] CMD_P = INSTRUCTION_WIDTH'(INSTRUCTION_CMD_PAUSE);
    localparam logic [INSTRUCTION_WIDTH-1:0] CMD_R = INSTRUCTION_WIDTH'(INSTRUCTION_CMD_RESUME);
    localparam logic [CNT_W-1:0] HIGH_LVL = CNT_W'(HIGH_WATER);
    localparam logic [CNT_W-1:0] LOW_LVL  = CNT_W'(LOW_WATER);

    logic [BEAT_W-1:0] in_word;
    logic [BEAT_W-1:0] head_word;
    logic [BEAT_W-1:0] load_word;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    logic in_valid, load_en, pop, bypass, push, drop, load;

    logic                        ld_last;
    logic [STREAM_ID_WIDTH-1:0]  ld_stream;
    logic [CHUNK_ID_WIDTH-1:0]   ld_chunk;
    logic [CHANNEL_ID_WIDTH-1:0] ld_channel;
    logic [STATE_WIDTH-1:0]      ld_state;
    logic [TYPE_WIDTH-1:0]       ld_type;
    logic [DATA_WIDTH-1:0]       ld_data;

    flow_state_e state_q;
    logic        paused_q;
    logic        pend_pause_q;
    logic        pend_resume_q;
    logic        raise_pause, raise_resume, req_pause, req_resume, slot_free;

    logic [DROP_CNT_WIDTH-1:0] drop_q;

    assign in_word = {dirOneFront_Last, dirOneFront_StreamID, dirOneFront_ChunkID,
                      dirOneFront_ChannelID, dirOneFront_State, dirOneFront_Type,
                      dirOneFront_Data};

    assign in_valid = (dirOneFront_Type != TYPE_IDLE);
    assign load_en  = (!paused_q && dirTwoBack_InstructionType != CMD_P) ||
                      (dirTwoBack_InstructionType == CMD_R);
    assign pop      = load_en && !fifo_empty;
    // An empty FIFO lets the incoming beat skip storage, keeping single-cycle latency.
    assign bypass   = load_en && fifo_empty && in_valid;
    assign push     = in_valid && !bypass && (!fifo_full || pop);
    assign drop     = in_valid && !bypass && fifo_full && !pop;
    assign load     = pop || bypass;

    assign load_word = fifo_empty ? in_word : head_word;
    assign {ld_last, ld_stream, ld_chunk, ld_channel, ld_state, ld_type, ld_data} = load_word;

    sync_fifo_fwft #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (push),
        .wr_data (in_word),
        .rd_en   (pop),
        .rd_data (head_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dirTwoBack_Data      <= '0;
            dirTwoBack_Type      <= TYPE_IDLE;
            dirTwoBack_Last      <= 1'b0;
            dirTwoBack_StreamID  <= '0;
            dirTwoBack_ChunkID   <= '0;
            dirTwoBack_ChannelID <= '0;
            dirTwoBack_State     <= '0;
            drop_q               <= '0;
        end else begin
            if (load) begin
                dirTwoBack_Data      <= ld_data;
                dirTwoBack_Type      <= ld_type;
                dirTwoBack_Last      <= ld_last;
                dirTwoBack_StreamID  <= ld_stream;
                dirTwoBack_ChunkID   <= ld_chunk;
                dirTwoBack_ChannelID <= ld_channel;
                dirTwoBack_State     <= ld_state;
            end else begin
                dirTwoBack_Type <= TYPE_IDLE;
            end
            if (drop && drop_q != {DROP_CNT_WIDTH{1'b1}}) begin
                drop_q <= drop_q + DROP_CNT_WIDTH'(1);
            end
        end
    end

    assign raise_pause  = (state_q == StRun) && (fifo_count >= HIGH_LVL);
    assign raise_resume = (state_q == StHeld) && (fifo_count <= LOW_LVL);
    // A fresh request of the opposite kind supersedes one still waiting for a slot.
    assign req_pause    = raise_pause || (pend_pause_q && !raise_resume);
    assign req_resume   = raise_resume || (pend_resume_q && !raise_pause);
    assign slot_free    = (dirTwoBack_InstructionType == CMD_I);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q                          <= StRun;
            paused_q                         <= 1'b0;
            pend_pause_q                     <= 1'b0;
            pend_resume_q                    <= 1'b0;
            dirOneFront_InstructionType      <= CMD_I;
            dirOneFront_InstructionStreamID  <= '0;
            dirOneFront_InstructionChannelID <= '0;
            dirOneFront_InstructionParameter <= '0;
        end else begin
            if (raise_pause) begin
                state_q <= StHeld;
            end else if (raise_resume) begin
                state_q <= StRun;
            end
            pend_pause_q  <= req_pause && !slot_free;
            pend_resume_q <= req_resume && !slot_free;

            if (dirTwoBack_InstructionType == CMD_P) begin
                paused_q <= 1'b1;
            end else if (dirTwoBack_InstructionType == CMD_R) begin
                paused_q <= 1'b0;
            end

            if (!slot_free || !(req_pause || req_resume)) begin
                dirOneFront_InstructionType      <= dirTwoBack_InstructionType;
                dirOneFront_InstructionStreamID  <= dirTwoBack_InstructionStreamID;
                dirOneFront_InstructionChannelID <= dirTwoBack_InstructionChannelID;
                dirOneFront_InstructionParameter <= dirTwoBack_InstructionParameter;
            end else begin
                dirOneFront_InstructionType      <= req_pause ? CMD_P : CMD_R;
                dirOneFront_InstructionStreamID  <= '0;
                dirOneFront_InstructionChannelID <= '0;
                dirOneFront_InstructionParameter <= INSTRUCTION_PARAMETER_WIDTH'(fifo_count);
            end
        end
    end

    assign fill_level = fifo_count;
    assign drop_count = drop_q;

endmodule

// File: doc/turn_around_fifo.md
# turn_around_fifo

Parametrised successor to the single-register loopback stage. Turns the direction-one forward stream around onto the direction-two backward stream through a DEPTH-entry FIFO, and passes backward instructions upstream. Honours downstream PAUSE/RESUME and generates its own upstream PAUSE/RESUME from FIFO fill watermarks. Sits at the far end of a stream chain, where data must return toward the host.

## Interface
- DATA_WIDTH, 512: data width, a multiple of 32.
- STREAM_ID_NUM / CHUNK_ID_NUM / CHANNEL_ID_NUM, 16 / 32 / 1024: ID ranges; *_WIDTH = $clog2 of each.
- STATE_WIDTH, 32: state field width.
- INSTRUCTION_WIDTH, 2; INSTRUCTION_PARAMETER_WIDTH, 16.
- INSTRUCTION_CMD_IDLE / _PAUSE / _RESUME, 0 / 1 / 2.
- DEPTH, 16: FIFO entries, power of two, ≥4.
- HIGH_WATER, 12: fill level at or above which an upstream PAUSE is requested.
- LOW_WATER, 4: fill level at or below which an upstream RESUME is requested. Requires LOW_WATER < HIGH_WATER < DEPTH.
- DROP_CNT_WIDTH, 16.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset; one clock; reset is synchronous and active-low.
- dirOneFront_Data/Type/Last/StreamID/ChunkID/ChannelID/State  in  DATA_WIDTH/2/1/STREAM_ID_WIDTH/CHUNK_ID_WIDTH/CHANNEL_ID_WIDTH/STATE_WIDTH  forward beat; a beat is valid when Type≠0.
- dirOneFront_InstructionType/StreamID/ChannelID/Parameter  out  instruction widths  instructions sent upstream.
- dirTwoBack_Data/Type/Last/StreamID/ChunkID/ChannelID/State  out  same widths as the forward beat  returned beat; Type=0 means idle.
- dirTwoBack_InstructionType/StreamID/ChannelID/Parameter  in  instruction widths  instructions from downstream.
- fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_count  out  DROP_CNT_WIDTH  dropped beats; saturates at all-ones.

## Operation
- Beat storage: each valid forward beat (all fields) is written to the FIFO. Order is preserved and idle beats are never stored.
- Output load: a new beat is loaded into the dirTwoBack output register at edge N when load-enable is true.
  - load-enable = (paused_q=0 and incoming instruction ≠ PAUSE) or incoming instruction = RESUME.
  - The loaded beat is the FIFO head if the FIFO is non-empty. Otherwise it is the incoming beat (bypass path).
  - If load-enable is false or nothing is available, dirTwoBack_Type=0 and the other output fields hold their values.
- Pause state:
  - paused_q is set by a downstream PAUSE and cleared by RESUME. The StreamID/ChannelID of these instructions are ignored.
  - All downstream instructions, PAUSE/RESUME included, are also forwarded upstream.
- Full FIFO: if the FIFO is full, the incoming beat is not bypassed and the head does not pop, the beat is dropped and drop_count increments.
- Simultaneous push and pop on a full FIFO is legal and loses no data.
- Flow control FSM, states RUN and HELD (upstream paused by us):
  - RUN→HELD when fill_level ≥ HIGH_WATER: a PAUSE request is raised as pending.
  - HELD→RUN when fill_level ≤ LOW_WATER: a RESUME request is raised as pending.
- Pending request emission:
  - A pending request is emitted only on a cycle whose registered downstream instruction is IDLE. Downstream instructions are never overwritten.
  - Emitted fields: StreamID=0, ChannelID=0, Parameter=fill_level zero-extended.
  - The request clears when emitted. A newer opposite request replaces an unemitted one.
- Reset (rstn=0 at an edge), including mid-operation:
  - FIFO is emptied and pending requests are discarded.
  - paused_q=0, FSM=RUN, drop_count=0, fill_level=0.
  - All dirTwoBack_* and dirOneFront_Instruction* outputs are 0 (InstructionType=IDLE).

## Timing
- Beat latency: 1 cycle when the FIFO is empty and the block is unpaused. A beat sampled at edge N appears after edge N, identical to the old register stage.
- Otherwise a beat waits one cycle per queued beat ahead of it.
- Instruction pass-through: 1 cycle, registered.
- Generated request latency: emitted the first edge after the watermark crossing on which the registered downstream slot is IDLE.
- Throughput: one beat per cycle in each direction.
- Headroom: DEPTH−HIGH_WATER must cover the upstream PAUSE reaction time. Beats arriving beyond that headroom are dropped and counted, never stalled.

## Structure
- Shared package holds the instruction command encodings, the Type idle value and the beat field-width derivations.
- One sub-module: sync_fifo_fwft. It is parametrised on width and depth and provides full, empty and count.
- The beat is packed as {Last, StreamID, ChunkID, ChannelID, State, Type, Data} into one FIFO word.

## Test plan
- Single beat, idle FIFO: Type=1, Data=0xA5… at edge 5 → dirTwoBack shows Type=1, Data=0xA5… after edge 5; fill_level stays 0.
- Downstream PAUSE, then 12 beats at 1/cycle → output Type=0 throughout. fill_level reaches 12 and one upstream PAUSE is emitted with Parameter=12. RESUME drains the 12 beats in order with counter data 0..11.
- Watermark release: starting from the 12-beat held state, drain to 4 → exactly one upstream RESUME is emitted with Parameter=4.
- Overflow: pause and push 20 beats with DEPTH=16 → drop_count=4, beats 0..15 are delivered after resume, and drop_count saturates when forced from 0xFFFF.
- Slot contention: a downstream instruction arrives every cycle while a PAUSE request is pending → all downstream instructions are forwarded unchanged, and the PAUSE appears on the first IDLE cycle.
- Reset mid-stream with 8 beats queued → all outputs are 0 the cycle after the reset edge, fill_level=0, and no stale beats appear afterwards.
